// File: rtl/loader_pkg.sv
// loader_pkg: shared loader states and word geometry; CHECK exists only with LOADER_CHECKSUM_EN
package loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_ADDR_STEP = 4;
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } loader_state_t;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: shifts bytes little-endian into a word (clk, rst_n, clr, shift_en, byte_in -> word, complete)
module word_assembler
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  complete
);
  logic [1:0] cnt;
  assign complete = shift_en && cnt == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift_en) begin
      word <= {byte_in, word[DATA_WIDTH-1:8]};
      cnt  <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: byte-stream instruction memory loader (start/byte stream in, wr_en/wr_addr/wr_data out, busy/done/chk_err; LOADER_CHECKSUM_EN adds XOR checksum byte)
module instr_loader
  import loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  chk_err
);
  localparam loader_state_t FIN = `ifdef LOADER_CHECKSUM_EN CHECK `else DONE `endif ;
  loader_state_t state, nxt;
  logic [31:0] len, wcnt, len_nxt;
  logic        take, arm, complete, last;
  assign take       = byte_valid && byte_ready;
  assign arm        = start && (state == IDLE || state == DONE);
  assign len_nxt    = {byte_data, len[31:8]};
  assign last       = (wcnt + 32'd1) == len;
  assign byte_ready = state == LEN || state == DATA `ifdef LOADER_CHECKSUM_EN || state == CHECK `endif ;
  assign wr_en      = state == WRITE;
  assign busy       = !(state == IDLE || state == DONE);
  assign done       = state == DONE;
  word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (arm),
    .shift_en (take && (state == LEN || state == DATA)),
    .byte_in  (byte_data),
    .word     (wr_data),
    .complete (complete)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = start ? LEN : IDLE;
      LEN:   nxt = complete ? (len_nxt == '0 ? FIN : DATA) : LEN;
      DATA:  nxt = complete ? WRITE : DATA;
      WRITE: nxt = last ? FIN : DATA;
`ifdef LOADER_CHECKSUM_EN
      CHECK: nxt = take ? DONE : CHECK;
`endif
      DONE:  nxt = start ? LEN : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len     <= '0;
      wcnt    <= '0;
      wr_addr <= BASE_ADDR;
    end else if (arm) begin
      wcnt    <= '0;
      wr_addr <= BASE_ADDR;
    end else if (state == LEN && take) begin
      len <= len_nxt;
    end else if (state == WRITE) begin
      wcnt    <= wcnt + 32'd1;
      wr_addr <= wr_addr + ADDR_WIDTH'(WORD_ADDR_STEP);
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      chk_err <= 1'b0;
    end else if (arm) begin
      acc     <= '0;
      chk_err <= 1'b0;
    end else if (state == DATA && take) begin
      acc <= acc ^ byte_data;
    end else if (state == CHECK && take) begin
      chk_err <= acc != byte_data;
    end
  end
`else
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed streams with a write scoreboard for instr_loader
module tb_instr_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, wr_en, busy, done, chk_err;
  logic [31:0] wr_addr, wr_data;
  int nvec = 0;
  int nerr = 0;
  logic [63:0] exp_q[$];
  instr_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .chk_err    (chk_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr_en", wr_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[63:32]);
        check("wr_data", wr_data, e[31:0]);
      end
    end
  end
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask
  task automatic send_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send(n[8*i +: 8]);
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(done), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask
  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, 32'(byte_ready), 32'd0);
    check({name, "_wr_en"}, 32'(wr_en), 32'd0);
    check({name, "_addr"}, wr_addr, 32'd0);
    check({name, "_data"}, wr_data, 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_chk"}, 32'(chk_err), 32'd0);
  endtask
  initial begin
    #12 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // single word stream
    pulse_start();
    check("armed_busy", 32'(busy), 32'd1);
    check("armed_ready", 32'(byte_ready), 32'd1);
    exp_q.push_back({32'h0, 32'h00A0_0513});
    send_len(32'd1);
    send(8'h13); send(8'h05); send(8'hA0); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'hB6);
`endif
    wait_done("one_word_done");
    check("one_word_chk", 32'(chk_err), 32'd0);
    // re-arm from DONE, three words with gaps, start ignored mid-DATA
    pulse_start();
    exp_q.push_back({32'h0, 32'h0403_0201});
    exp_q.push_back({32'h4, 32'h0807_0605});
    exp_q.push_back({32'h8, 32'h0C0B_0A09});
    send_len(32'd3);
    for (int i = 1; i <= 12; i++) begin
      send(8'(i));
      if (i == 2) pulse_start();
      @(negedge clk);
    end
    check("start_ignored_busy", 32'(busy), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    send(8'h0C);
`endif
    wait_done("three_word_done");
    // zero length
    pulse_start();
    send_len(32'd0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    wait_done("zero_len_done");
    // reset mid-transfer
    pulse_start();
    exp_q.push_back({32'h0, 32'h4433_2211});
    send_len(32'd2);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("after_reset_busy", 32'(busy), 32'd0);
    check("after_reset_done", 32'(done), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    exp_q.push_back({32'h0, 32'h4433_2211});
    send_len(32'd1);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h44);
    wait_done("chk_ok_done");
    check("chk_ok", 32'(chk_err), 32'd0);
    pulse_start();
    exp_q.push_back({32'h0, 32'h4433_2211});
    send_len(32'd1);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h45);
    wait_done("chk_bad_done");
    check("chk_bad", 32'(chk_err), 32'd1);
`endif
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
